lcd_sync_fifo: RTL and testbench
================================

Name: lcd_sync_fifo

Overview:
Parametrised single-clock FIFO for the LCD driver datapath. It buffers command and pixel words between the host-side writer and the LCD timing engine. It provides the full DEPTH capacity, registered status flags, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. A selectable first-word-fall-through (FWFT) read mode lets the LCD engine see the head word without a read cycle.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 2, pointer width; DEPTH = 1<<ADDR_WIDTH
DEPTH, 1<<ADDR_WIDTH, storage entries, all usable
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-low reset
data_in  in  DATA_WIDTH  write data
wr  in  1  write request
rd  in  1  read request (pop)
flush  in  1  synchronous clear of contents
clr_err  in  1  clears overflow/underflow
data_out  out  DATA_WIDTH  read data
empty, full  out  1  status from registered count
almost_empty, almost_full  out  1  threshold status
overflow, underflow  out  1  sticky error flags
fifo_cnt  out  ADDR_WIDTH+1  stored word count, 0..DEPTH

Behaviour:
- Reset (reset=0, asynchronous): rd_ptr=wr_ptr=0, fifo_cnt=0, data_out=0, overflow=underflow=0. Flags follow the count: empty=1, almost_empty=1, full=0, almost_full=(AF_LEVEL==0). RAM contents are not reset. Deassertion is sampled on the next clk edge.
- All flags decode the registered fifo_cnt (no next-state decode): full=(cnt==DEPTH), empty=(cnt==0).
- Read accept: rd_acc = rd && !empty.
- Write accept: wr_acc = wr && (!full || rd_acc). A write to a full FIFO with a simultaneous accepted read succeeds. A write with rd to an empty FIFO accepts only the write.
- On a clock edge:
  - wr_acc: ram[wr_ptr] <= data_in; wr_ptr increments.
  - rd_acc: rd_ptr increments.
  - Both pointers wrap modulo DEPTH.
- Count update: cnt += wr_acc - rd_acc, which never leaves 0..DEPTH.
- FWFT=0: data_out <= ram[rd_ptr] on an edge with rd_acc; otherwise it holds its value. Read latency is 1 cycle.
- FWFT=1: data_out = empty ? 0 : ram[rd_ptr], combinational from the registered pointer. A word written at edge N appears after edge N. rd_acc advances to the next word.
- overflow is set on any edge with wr && !wr_acc. underflow is set on any edge with rd && empty. Both hold until clr_err or reset. If clr_err and a new error occur in the same cycle, set wins.
- Rejected accesses change no pointer, count or data.
- flush has highest priority over wr/rd. On the edge: pointers=0, cnt=0, data_out=0. Error flags are unaffected. wr/rd in the same cycle are ignored and flag no error.
- Reset asserted mid-transfer aborts immediately: all state returns to reset values with no partial write.

Decomposition:
- Package lcd_fifo_pkg: default DATA_WIDTH/ADDR_WIDTH constants and the FWFT mode constants (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1).
- One sub-module, lcd_fifo_ram: DEPTH x DATA_WIDTH storage with synchronous write and asynchronous read by address. Control, count and flags stay in lcd_sync_fifo.

Test Plan:
1. DEPTH=4, FWFT=0. Write 0x11,0x22,0x33,0x44 → fifo_cnt=4, full=1, almost_full=1. Fifth write 0x55 → overflow=1, cnt stays 4. Four reads → data_out 0x11..0x44, each 1 cycle after its rd; then empty=1.
2. Full FIFO, rd=wr=1 with data_in=0x99 → cnt stays 4, no overflow. Subsequent reads return 0x22,0x33,0x44,0x99.
3. Empty FIFO, rd=1 → underflow=1, data_out holds its last value, cnt=0. clr_err pulse → underflow=0.
4. FWFT=1. Write 0xA5 → data_out=0xA5 the cycle after the write with no rd. rd pops it; empty=1 and data_out=0.
5. Twenty interleaved write/read pairs, data 0x00..0x13 → pointer wrap-around, in-order output, no errors, cnt never exceeds 2.
6. Write 3 words then pulse flush with wr=1 → cnt=0, empty=1, no overflow. Drive reset low mid-write → immediate reset values, data_out=0.

Source files
------------

// File: rtl/lcd_fifo_pkg.sv
// Shared constants for the LCD driver FIFO: default geometry and read-mode selectors.
package lcd_fifo_pkg;

    localparam int LCD_FIFO_DATA_WIDTH = 8;
    localparam int LCD_FIFO_ADDR_WIDTH = 2;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

endpackage

// File: rtl/lcd_fifo_ram.sv
// DEPTH x DATA_WIDTH storage for the LCD FIFO: synchronous write, asynchronous read.
module lcd_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];

    // NOTE: storage is deliberately left out of reset; the pointers and count define which words are valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_sync_fifo.sv
// Single-clock FIFO between the LCD host writer and timing engine, with threshold
// flags, sticky error flags, synchronous flush and an optional first-word-fall-through read port.
module lcd_sync_fifo
    import lcd_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = LCD_FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = LCD_FIFO_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_cnt
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0]         AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0]         CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  rd_acc, wr_acc, ram_we;
    logic                  ovf_evt, unf_evt;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_C);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign fifo_cnt     = cnt;

    // Flush masks both requests, so a flushing cycle neither moves data nor raises an error.
    assign rd_acc  = !flush && rd && !empty;
    assign wr_acc  = !flush && wr && (!full || rd_acc);
    assign ovf_evt = !flush && wr && !wr_acc;
    assign unf_evt = !flush && rd && empty;

    // The RAM has no reset, so a write coinciding with reset assertion is blocked here.
    assign ram_we = wr_acc && reset;

    lcd_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (unf_evt)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign data_out = empty ? '0 : ram_rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dout_q <= '0;
                end else if (flush) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= ram_rdata;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_lcd_sync_fifo.sv
// Scoreboard bench for lcd_sync_fifo: one registered-read and one FWFT instance share
// the same stimulus and are compared against a queue-based reference model.
module tb_lcd_sync_fifo;
    import lcd_fifo_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic          f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [AW:0]   s_cnt, f_cnt;

    lcd_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_MODE_STD)) u_std (
        .clk(clk), .reset(reset), .data_in(data_in), .wr(wr), .rd(rd), .flush(flush),
        .clr_err(clr_err), .data_out(s_dout), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .overflow(s_ovf), .underflow(s_unf),
        .fifo_cnt(s_cnt)
    );

    lcd_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_MODE_FWFT)) u_fwft (
        .clk(clk), .reset(reset), .data_in(data_in), .wr(wr), .rd(rd), .flush(flush),
        .clr_err(clr_err), .data_out(f_dout), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .overflow(f_ovf), .underflow(f_unf),
        .fifo_cnt(f_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int max_cnt = 0;

    logic [DW-1:0] mq[$];     // reference contents, head at index 0
    logic [DW-1:0] exp_q[$];  // expected registered-read words, in pop order
    logic          m_ovf = 1'b0, m_unf = 1'b0;
    logic [DW-1:0] m_dout = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endfunction

    // Behavioural FIFO: a bounded queue with pop-before-push when both are requested.
    function automatic void model_step(input bit w, input bit r, input bit fl, input bit ce,
                                       input logic [DW-1:0] d);
        bit rok, wok;
        if (fl) begin
            mq.delete();
            m_dout = '0;
        end else begin
            rok = r && (mq.size() != 0);
            wok = w && ((mq.size() < DEPTH) || rok);
            if (w && !wok)          m_ovf = 1'b1;
            else if (ce)            m_ovf = 1'b0;
            if (r && mq.size() == 0) m_unf = 1'b1;
            else if (ce)            m_unf = 1'b0;
            if (rok) begin
                m_dout = mq.pop_front();
                exp_q.push_back(m_dout);
            end
            if (wok) mq.push_back(d);
        end
    endfunction

    task automatic check_status();
        int n;
        n = mq.size();
        check("cnt_std",   32'(s_cnt), 32'(n));
        check("cnt_fwft",  32'(f_cnt), 32'(n));
        check("empty_std", 32'(s_empty), 32'(n == 0));
        check("full_std",  32'(s_full),  32'(n == DEPTH));
        check("ae_std",    32'(s_ae),    32'(n <= 1));
        check("af_std",    32'(s_af),    32'(n >= DEPTH - 1));
        check("empty_fwft", 32'(f_empty), 32'(n == 0));
        check("full_fwft",  32'(f_full),  32'(n == DEPTH));
        check("ovf_std",   32'(s_ovf), 32'(m_ovf));
        check("unf_std",   32'(s_unf), 32'(m_unf));
        check("ovf_fwft",  32'(f_ovf), 32'(m_ovf));
        check("unf_fwft",  32'(f_unf), 32'(m_unf));
        check("dout_std",  32'(s_dout), 32'(m_dout));
        check("dout_fwft", 32'(f_dout), (n == 0) ? 32'h0 : 32'(mq[0]));
        if (int'(s_cnt) > max_cnt) max_cnt = int'(s_cnt);
    endtask

    task automatic cycle(input bit w, input bit r, input bit fl, input bit ce,
                         input logic [DW-1:0] d);
        @(negedge clk);
        wr = w; rd = r; flush = fl; clr_err = ce; data_in = d;
        model_step(w, r, fl, ce, d);
        @(posedge clk);
        #1;
        check_status();
    endtask

    // Monitor: each accepted pop on the registered-read port must present the next scoreboard word.
    initial begin
        forever begin
            @(posedge clk);
            if (reset && rd && !flush && !s_empty) begin
                #1;
                if (exp_q.size() == 0) check("sb_unexpected_read", 32'h1, 32'h0);
                else                   check("sb_read_data", 32'(s_dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1;
        check("rst_cnt",   32'(s_cnt), 32'h0);
        check("rst_empty", 32'(s_empty), 32'h1);
        check("rst_ae",    32'(s_ae), 32'h1);
        check("rst_full",  32'(s_full), 32'h0);
        check("rst_af",    32'(s_af), 32'h0);
        check("rst_dout",  32'(s_dout), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Fill, overflow, drain in order.
        cycle(1, 0, 0, 0, 8'h11);
        cycle(1, 0, 0, 0, 8'h22);
        cycle(1, 0, 0, 0, 8'h33);
        cycle(1, 0, 0, 0, 8'h44);
        check("t1_full", 32'(s_full), 32'h1);
        check("t1_cnt4", 32'(s_cnt), 32'h4);
        cycle(1, 0, 0, 0, 8'h55);
        check("t1_overflow", 32'(s_ovf), 32'h1);
        cycle(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 8'h00);
        check("t1_last_word", 32'(s_dout), 32'h44);

        // Simultaneous read and write on a full FIFO.
        for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 0, 8'(i * 8'h11));
        cycle(1, 1, 0, 0, 8'h99);
        check("t2_no_overflow", 32'(s_ovf), 32'h0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 8'h00);
        check("t2_tail_word", 32'(s_dout), 32'h99);

        // Underflow holds data_out, then clears.
        cycle(0, 1, 0, 0, 8'h00);
        check("t3_underflow", 32'(s_unf), 32'h1);
        check("t3_dout_hold", 32'(s_dout), 32'h99);
        cycle(0, 0, 0, 1, 8'h00);
        check("t3_unf_clear", 32'(s_unf), 32'h0);

        // First-word-fall-through visibility.
        cycle(1, 0, 0, 0, 8'hA5);
        check("t4_fwft_head", 32'(f_dout), 32'hA5);
        cycle(0, 1, 0, 0, 8'h00);
        check("t4_fwft_zero", 32'(f_dout), 32'h0);

        // Interleaved pairs across pointer wrap.
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 0, 8'(i));
            cycle(0, 1, 0, 0, 8'h00);
        end
        check("t5_max_cnt_le2", 32'(max_cnt <= 2), 32'h1);
        check("t5_no_errors", 32'({s_ovf, s_unf}), 32'h0);

        // Flush beats a concurrent write and raises no error.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 8'(8'hC0 + i));
        cycle(1, 0, 1, 0, 8'h77);
        check("t6_flush_cnt", 32'(s_cnt), 32'h0);
        check("t6_flush_ovf", 32'(s_ovf), 32'h0);

        // Randomised traffic with alternating fill and drain bias.
        for (int i = 0; i < 400; i++) begin
            int  wp;
            bit  w, r, fl, ce;
            wp = ((i / 50) % 2 == 0) ? 75 : 25;
            w  = ($urandom_range(0, 99) < wp);
            r  = ($urandom_range(0, 99) < (100 - wp));
            fl = ($urandom_range(0, 39) == 0);
            ce = !fl && ($urandom_range(0, 9) == 0);
            cycle(w, r, fl, ce, 8'($urandom));
        end

        // Reset asserted in the middle of a write.
        cycle(1, 0, 0, 0, 8'h3C);
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = 8'hEE;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("t6_rst_cnt",   32'(s_cnt), 32'h0);
        check("t6_rst_dout",  32'(s_dout), 32'h0);
        check("t6_rst_fdout", 32'(f_dout), 32'h0);
        check("t6_rst_empty", 32'(s_empty), 32'h1);
        check("t6_rst_err",   32'({s_ovf, s_unf, f_ovf, f_unf}), 32'h0);
        @(posedge clk);
        #1;
        check("t6_rst_hold_cnt", 32'(s_cnt), 32'h0);
        @(negedge clk);
        wr = 1'b0;
        reset = 1'b1;
        cycle(0, 0, 0, 0, 8'h00);

        #20;
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
